pipelined_decode_stage: RTL and testbench

PIPELINED_DECODE_STAGE -- requirements
Module: pipelined_decode_stage

---
 rtl/pipelined_decode_stage.sv | 178 +++++++++++++++++
 tb/tb_pipelined_decode_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_decode_stage.sv
// rtl/pipelined_decode_stage.sv - registered instruction decode stage with load-use scoreboard and stall counter
// Optional NIC access decode for LD/SD is enabled by defining NIC_DECODE_EN.
module pipelined_decode_stage #(
    parameter int LOAD_LAT    = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_instr,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_rega,
    output logic [4:0]             out_regb,
    output logic [4:0]             out_rd,
    output logic [5:0]             out_op,
    output logic [1:0]             out_ww,
    output logic [2:0]             out_ppp,
    output logic [1:0]             out_br,
    output logic [15:0]            out_imm,
    output logic                   out_wr_en,
    output logic                   out_mem_en,
    output logic                   out_store_en,
    output logic                   out_load,
    output logic                   out_nic_en,
    output logic                   out_nic_wr,
    output logic                   out_illegal,
    output logic [1:0]             out_nic_sel,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b101010;
    localparam logic [5:0] OP_VBNZ  = 6'b100010;
    localparam logic [5:0] OP_VBEZ  = 6'b100011;
    localparam logic [5:0] OP_LD    = 6'b100000;
    localparam logic [5:0] OP_SD    = 6'b100001;
    localparam logic [5:0] OP_NOP   = 6'b111100;

    typedef struct packed {
        logic [4:0]  rega;
        logic [4:0]  regb;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic [1:0]  ww;
        logic [2:0]  ppp;
        logic [1:0]  br;
        logic [15:0] imm;
        logic        wr_en;
        logic        mem_en;
        logic        store_en;
        logic        load;
        logic        nic_en;
        logic        nic_wr;
        logic        illegal;
        logic [1:0]  nic_sel;
    } bundle_t;

    bundle_t dec;
    bundle_t bun;
    logic    hazard;
    logic    accept;

    logic [LOAD_LAT-1:0] sb_valid;
    logic [4:0]          sb_rd [LOAD_LAT];

    always_comb begin
        dec = '0;
        case (in_instr[31:26])
            OP_RTYPE: begin
                dec.rd    = in_instr[25:21];
                dec.rega  = in_instr[20:16];
                dec.regb  = in_instr[15:11];
                dec.ppp   = in_instr[10:8];
                dec.ww    = in_instr[7:6];
                dec.op    = in_instr[5:0];
                dec.wr_en = 1'b1;
            end
            OP_VBNZ, OP_VBEZ: begin
                dec.br   = {1'b1, in_instr[26]};
                dec.rega = in_instr[25:21];
                dec.imm  = in_instr[15:0];
            end
            OP_LD: begin
                dec.rd     = in_instr[25:21];
                dec.imm    = in_instr[15:0];
                dec.mem_en = 1'b1;
                dec.wr_en  = 1'b1;
                dec.load   = 1'b1;
`ifdef NIC_DECODE_EN
                if (in_instr[15:14] == 2'b11 && in_instr[1:0] != 2'b00) begin
                    dec.nic_en  = 1'b1;
                    dec.nic_sel = in_instr[1:0];
                    dec.load    = 1'b0;
                end
`endif
            end
            OP_SD: begin
                dec.rega     = in_instr[25:21];
                dec.imm      = in_instr[15:0];
                dec.mem_en   = 1'b1;
                dec.store_en = 1'b1;
`ifdef NIC_DECODE_EN
                if (in_instr[15:14] == 2'b11 && in_instr[1:0] == 2'b10) begin
                    dec.nic_en  = 1'b1;
                    dec.nic_wr  = 1'b1;
                    dec.nic_sel = 2'b11;
                end
`endif
            end
            OP_NOP:  dec = '0;
            default: dec.illegal = 1'b1;
        endcase
    end

    // Only sources the opcode actually defines are nonzero in dec, so they alone can raise a hazard.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (sb_valid[i] &&
                ((dec.rega != 5'd0 && dec.rega == sb_rd[i]) ||
                 (dec.regb != 5'd0 && dec.regb == sb_rd[i])))
                hazard = 1'b1;
        end
    end

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            bun       <= '0;
            sb_valid  <= '0;
            for (int i = 0; i < LOAD_LAT; i++) sb_rd[i] <= 5'd0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                bun       <= dec;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Entry drops off the tail exactly LOAD_LAT edges after the load was accepted.
            sb_valid[0] <= accept && (in_instr[31:26] == OP_LD) && (dec.rd != 5'd0);
            sb_rd[0]    <= dec.rd;
            for (int i = 1; i < LOAD_LAT; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end

            if (in_valid && hazard && stall_cnt != {STALL_CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_rega     = bun.rega;
    assign out_regb     = bun.regb;
    assign out_rd       = bun.rd;
    assign out_op       = bun.op;
    assign out_ww       = bun.ww;
    assign out_ppp      = bun.ppp;
    assign out_br       = bun.br;
    assign out_imm      = bun.imm;
    assign out_wr_en    = bun.wr_en;
    assign out_mem_en   = bun.mem_en;
    assign out_store_en = bun.store_en;
    assign out_load     = bun.load;
    assign out_nic_en   = bun.nic_en;
    assign out_nic_wr   = bun.nic_wr;
    assign out_illegal  = bun.illegal;
    assign out_nic_sel  = bun.nic_sel;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// tb/tb_pipelined_decode_stage.sv - directed self-checking bench for pipelined_decode_stage
module tb_pipelined_decode_stage;

    localparam int LL = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]   in_instr;
    logic [4:0]    out_rega, out_regb, out_rd;
    logic [5:0]    out_op;
    logic [1:0]    out_ww, out_br, out_nic_sel;
    logic [2:0]    out_ppp;
    logic [15:0]   out_imm;
    logic          out_wr_en, out_mem_en, out_store_en, out_load;
    logic          out_nic_en, out_nic_wr, out_illegal;
    logic [SW-1:0] stall_cnt;
    logic [6:0]    flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign flags = {out_wr_en, out_mem_en, out_store_en, out_load, out_nic_en, out_nic_wr, out_illegal};

    pipelined_decode_stage #(.LOAD_LAT(LL), .STALL_CNT_W(SW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_rega(out_rega), .out_regb(out_regb), .out_rd(out_rd), .out_op(out_op),
        .out_ww(out_ww), .out_ppp(out_ppp), .out_br(out_br), .out_imm(out_imm),
        .out_wr_en(out_wr_en), .out_mem_en(out_mem_en), .out_store_en(out_store_en),
        .out_load(out_load), .out_nic_en(out_nic_en), .out_nic_wr(out_nic_wr),
        .out_illegal(out_illegal), .out_nic_sel(out_nic_sel), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {6'b101010, rd, a, b, 11'h000};
    endfunction

    function automatic logic [31:0] ld(input logic [4:0] rd, input logic [15:0] imm);
        return {6'b100000, rd, 5'd0, imm};
    endfunction

    function automatic logic [31:0] sd(input logic [4:0] a, input logic [15:0] imm);
        return {6'b100001, a, 5'd0, imm};
    endfunction

    task automatic send(input string tag, input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        #1 chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_vld"}, out_valid, 1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_vld", out_valid, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_flags", flags, 0);
        chk("rst_rd", out_rd, 0);
        #1 chk("rst_rdy", in_ready, 1);

        send("rtype", 32'hA8A21A45);
        chk("rt_rd", out_rd, 5);
        chk("rt_a", out_rega, 2);
        chk("rt_b", out_regb, 3);
        chk("rt_ppp", out_ppp, 2);
        chk("rt_ww", out_ww, 1);
        chk("rt_op", out_op, 6'h05);
        chk("rt_flags", flags, 7'b1000000);
        chk("rt_imm", out_imm, 0);

        // load-use stall of exactly LOAD_LAT cycles
        send("ld4", ld(5'd4, 16'h0010));
        chk("ld4_flags", flags, 7'b1101000);
        chk("ld4_rd", out_rd, 4);
        in_valid = 1'b1; in_instr = rtype(5'd6, 5'd4, 5'd0);
        #1 chk("st_rdy0", in_ready, 0);
        tick();
        chk("st_cnt1", stall_cnt, 1);
        #1 chk("st_rdy1", in_ready, 0);
        tick();
        chk("st_cnt2", stall_cnt, 2);
        #1 chk("st_rdy2", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("st_vld", out_valid, 1);
        chk("st_rd", out_rd, 6);
        chk("st_a", out_rega, 4);

        // second stall on source B pushes the 2-bit counter into saturation
        send("ld7", ld(5'd7, 16'h0000));
        in_valid = 1'b1; in_instr = rtype(5'd8, 5'd0, 5'd7);
        #1 chk("sat_rdy0", in_ready, 0);
        tick();
        chk("sat_cnt3", stall_cnt, 3);
        tick();
        chk("sat_hold", stall_cnt, 3);
        #1 chk("sat_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("sat_b", out_regb, 7);
        chk("sat_rd", out_rd, 8);

        // backpressure for 3 cycles
        send("bp1", rtype(5'd1, 5'd0, 5'd0));
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = rtype(5'd2, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy", in_ready, 0);
            chk("bp_vld", out_valid, 1);
            chk("bp_rd", out_rd, 1);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_rel_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp2_vld", out_valid, 1);
        chk("bp2_rd", out_rd, 2);
        tick();
        chk("bp_drain", out_valid, 0);

        // flush with a held bundle blocks acceptance
        send("fl3", rtype(5'd3, 5'd0, 5'd0));
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = rtype(5'd4, 5'd0, 5'd0); flush = 1'b1;
        #1 chk("fl_rdy", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("fl_vld", out_valid, 0);
        chk("fl_rd", out_rd, 3);
        #1 chk("fl_rdy2", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("fl4_vld", out_valid, 1);
        chk("fl4_rd", out_rd, 4);
        out_ready = 1'b1;

        // flush leaves the scoreboard intact
        send("ld9", ld(5'd9, 16'h0000));
        in_valid = 1'b1; in_instr = rtype(5'd10, 5'd9, 5'd0); flush = 1'b1;
        tick();
        flush = 1'b0;
        #1 chk("fsb_rdy", in_ready, 0);
        tick();
        #1 chk("fsb_rdy2", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("fsb_rd", out_rd, 10);

        send("vbnz", {6'b100010, 5'd10, 5'd0, 16'h1234});
        chk("vbnz_br", out_br, 2);
        chk("vbnz_a", out_rega, 10);
        chk("vbnz_imm", out_imm, 16'h1234);
        chk("vbnz_rd", out_rd, 0);
        chk("vbnz_flags", flags, 0);
        send("vbez", {6'b100011, 5'd3, 5'd0, 16'hBEEF});
        chk("vbez_br", out_br, 3);
        chk("vbez_imm", out_imm, 16'hBEEF);
        send("sd", sd(5'd11, 16'h0008));
        chk("sd_a", out_rega, 11);
        chk("sd_imm", out_imm, 8);
        chk("sd_flags", flags, 7'b0110000);
        send("nop", {6'b111100, 26'h3FFFFFF});
        chk("nop_flags", flags, 0);
        chk("nop_rd", out_rd, 0);
        chk("nop_imm", out_imm, 0);
        send("ill", {6'h3F, 26'h3FFFFFF});
        chk("ill_flags", flags, 7'b0000001);
        chk("ill_rd", out_rd, 0);
        chk("ill_op", out_op, 0);

        send("nicld", ld(5'd12, 16'hC001));
        chk("nicld_rd", out_rd, 12);
`ifdef NIC_DECODE_EN
        chk("nicld_flags", flags, 7'b1100100);
        chk("nicld_sel", out_nic_sel, 1);
`else
        chk("nicld_flags", flags, 7'b1101000);
        chk("nicld_sel", out_nic_sel, 0);
`endif
        send("nicsd", sd(5'd14, 16'hC002));
`ifdef NIC_DECODE_EN
        chk("nicsd_flags", flags, 7'b0110110);
        chk("nicsd_sel", out_nic_sel, 3);
`else
        chk("nicsd_flags", flags, 7'b0110000);
        chk("nicsd_sel", out_nic_sel, 0);
`endif

        // reset during a pending stall
        send("ld13", ld(5'd13, 16'h0000));
        in_valid = 1'b1; in_instr = rtype(5'd15, 5'd13, 5'd0);
        #1 chk("rs_rdy0", in_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_vld", out_valid, 0);
        chk("rs_rd", out_rd, 0);
        chk("rs_imm", out_imm, 0);
        chk("rs_flags", flags, 0);
        chk("rs_cnt", stall_cnt, 0);
        #1 chk("rs_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("rs_acc_vld", out_valid, 1);
        chk("rs_acc_rd", out_rd, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
